// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration loader.
// State encoding, default pad word and config-word field offsets.
package gpio_cfg_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIFT_LO = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_LOAD     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        SHIFT_LO = ST_SHIFT_LO,
        SHIFT_HI = ST_SHIFT_HI,
        LOAD     = ST_LOAD,
        DONE     = ST_DONE
    } state_t;

    localparam logic [12:0] CFG_RESET_DEFAULT = 13'h0403;

    localparam int MGMT_EN     = 0;
    localparam int OUT_DIS     = 1;
    localparam int HOLDOVER    = 2;
    localparam int INP_DIS     = 3;
    localparam int IB_MODE_SEL = 4;
    localparam int ANALOG_EN   = 5;
    localparam int ANALOG_SEL  = 6;
    localparam int ANALOG_POL  = 7;
    localparam int SLOW_SEL    = 8;
    localparam int VTRIP_SEL   = 9;
    localparam int DM_LO       = 10;
    localparam int DM_HI       = 12;

endpackage

// File: rtl/gpio_cfg_clkdiv.sv
// Half-period counter for the serial chain clock.
// Emits a one-cycle tick every CLK_DIV enabled cycles.
module gpio_cfg_clkdiv #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_cfg_loader.sv
// Per-pad config register file plus serial chain loader.
// GPIO_CFG_AUTOLOAD_EN: run one load sequence right after each reset.
module gpio_cfg_loader
    import gpio_cfg_pkg::*;
#(
    parameter int                  TOTAL_PADS = 38,
    parameter int                  CFG_BITS   = 13,
    parameter int                  CLK_DIV    = 2,
    parameter logic [CFG_BITS-1:0] CFG_RESET  = CFG_BITS'(CFG_RESET_DEFAULT),
    parameter int                  AW         = 6
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    output logic [CFG_BITS-1:0] cfg_rdata,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                wr_drop,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load
);

    localparam int TOT = TOTAL_PADS * CFG_BITS;
    localparam int BW  = $clog2(TOT);

    state_t              state;
    logic [CFG_BITS-1:0] regs [TOTAL_PADS];
    logic [TOT-1:0]      flat_next;
    logic [TOT-1:0]      sreg;
    logic [BW-1:0]       bit_cnt;
    logic                half;
    logic                tick;
    logic                div_en;
    logic                addr_ok;
    logic                wr_ok;
    logic                go;

    assign addr_ok = 32'(cfg_addr) < 32'(TOTAL_PADS);
    assign wr_ok   = cfg_we && (state == IDLE) && addr_ok;
    assign div_en  = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LOAD);

`ifdef GPIO_CFG_AUTOLOAD_EN
    logic auto_pend;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            auto_pend <= 1'b1;
        end else if (state == IDLE) begin
            auto_pend <= 1'b0;
        end
    end

    assign go = start || auto_pend;
`else
    assign go = start;
`endif

    gpio_cfg_clkdiv #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (wb_clk_i),
        .clear  (wb_rst_i || !div_en),
        .enable (div_en),
        .tick   (tick)
    );

    always_comb begin
        cfg_rdata = '0;
        for (int i = 0; i < TOTAL_PADS; i++) begin
            if (cfg_addr == AW'(i)) cfg_rdata = regs[i];
        end
    end

    // Snapshot includes a write landing in the same cycle as start.
    always_comb begin
        flat_next = '0;
        for (int p = 0; p < TOTAL_PADS; p++) begin
            flat_next[p*CFG_BITS +: CFG_BITS] =
                (wr_ok && cfg_addr == AW'(p)) ? cfg_wdata : regs[p];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_drop      <= 1'b0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
            bit_cnt      <= '0;
            half         <= 1'b0;
            sreg         <= '0;
            for (int i = 0; i < TOTAL_PADS; i++) regs[i] <= CFG_RESET;
        end else begin
            done    <= 1'b0;
            wr_drop <= cfg_we && !wr_ok;
            for (int i = 0; i < TOTAL_PADS; i++) begin
                if (wr_ok && cfg_addr == AW'(i)) regs[i] <= cfg_wdata;
            end
            case (state)
                IDLE: begin
                    if (go) begin
                        state        <= SHIFT_LO;
                        busy         <= 1'b1;
                        bit_cnt      <= BW'(TOT - 1);
                        sreg         <= flat_next;
                        serial_data  <= flat_next[TOT-1];
                        serial_clock <= 1'b0;
                        half         <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        state        <= SHIFT_HI;
                        serial_clock <= 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        serial_clock <= 1'b0;
                        if (bit_cnt == '0) begin
                            state       <= LOAD;
                            serial_load <= 1'b1;
                            serial_data <= 1'b0;
                        end else begin
                            state       <= SHIFT_LO;
                            bit_cnt     <= bit_cnt - 1'b1;
                            sreg        <= sreg << 1;
                            serial_data <= sreg[TOT-2];
                        end
                    end
                end
                LOAD: begin
                    if (tick) begin
                        if (half) begin
                            state       <= DONE;
                            serial_load <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            half <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
